rpn_controller: RTL and testbench

Sequencing controller for the RPN calculator datapath. It accepts stack commands over a valid/ready handshake and keeps an operand stack of 8-bit values. For each arithmetic/logic command it drives the shared 3-bit-opcode 8-bit ALU with registered operands, captures the ALU result and writes it back onto the stack. It sits between the command source (keypad decoder or host) and the combinational ALU, and reports the new top of stack and an error code per command.

---
 rtl/rpn_pkg.sv | 37 +++
 rtl/rpn_if.sv | 23 ++
 rtl/rpn_stack.sv | 51 +++++
 rtl/rpn_controller.sv | 148 ++++++++++++++
 tb/tb_rpn_controller.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared encodings for the RPN controller.
// Contents: command opcodes, ALU opcodes, response error codes, FSM state enum,
// default stack depth and the command-to-ALU opcode mapping helper.
package rpn_pkg;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        CMD_PUSH = 3'b000,
        CMD_ADD  = 3'b001,
        CMD_SUB  = 3'b010,
        CMD_AND  = 3'b011,
        CMD_NOT  = 3'b100,
        CMD_OR   = 3'b101,
        CMD_POP  = 3'b110,
        CMD_DUP  = 3'b111
    } cmd_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_EXEC, S_WB, S_RESP} state_e;

    function automatic logic [2:0] alu_op_of(cmd_e c);
        return c == CMD_SUB ? ALU_SUB :
               c == CMD_AND ? ALU_AND :
               c == CMD_NOT ? ALU_NOT :
               c == CMD_OR  ? ALU_OR  : ALU_ADD;
    endfunction
endpackage

// File: rtl/rpn_if.sv
// rpn_if: command/response handshake bundle of the RPN controller.
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_data (command channel),
// rsp_valid/rsp_ready/rsp_top/rsp_err (response channel).
// master = command source side, slave = controller side.
interface rpn_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_top;
    logic [1:0] rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_top, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_top, rsp_err
    );
endinterface

// File: rtl/rpn_stack.sv
// rpn_stack: register-file operand stack of 8-bit entries.
// Ports: clk, reset (sync, active-high, clears depth);
// push_i/pop_i/pop2push_i/repl_i strobes (at most one per cycle) with wdata_i;
// tos_o/nos_o top and next-on-stack reads; depth_o/full_o/empty_o occupancy.
module rpn_stack #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         pop2push_i,
    input  logic                         repl_i,
    input  logic [7:0]                   wdata_i,
    output logic [7:0]                   tos_o,
    output logic [7:0]                   nos_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic [AW-1:0] t_idx, n_idx, w_idx;

    always_comb begin
        t_idx   = AW'(depth_q - DW'(1));
        n_idx   = AW'(depth_q - DW'(2));
        // pop2push lands the result where NOS was, shrinking the stack by one
        w_idx   = push_i ? AW'(depth_q) : pop2push_i ? n_idx : t_idx;
        depth_d = push_i ? depth_q + DW'(1) :
                  (pop_i || pop2push_i) ? depth_q - DW'(1) : depth_q;
    end

    always_ff @(posedge clk) begin
        if (reset) depth_q <= '0;
        else       depth_q <= depth_d;
    end

    always_ff @(posedge clk) begin
        if (push_i || pop2push_i || repl_i) mem_q[w_idx] <= wdata_i;
    end

    assign depth_o = depth_q;
    assign full_o  = depth_q == DW'(DEPTH);
    assign empty_o = depth_q == '0;
    assign tos_o   = empty_o ? 8'h00 : mem_q[t_idx];
    assign nos_o   = mem_q[n_idx];
endmodule

// File: rtl/rpn_controller.sv
// rpn_controller: command sequencer for the RPN calculator stack and external ALU.
// Ports: clk, reset (sync, active-high); bus (rpn_if.slave command/response);
// alu_ain_o/alu_bin_o/alu_op_o registered ALU operands and opcode; alu_out_i ALU result;
// depth_o/full_o/empty_o stack occupancy.
// Build option: define RPN_DUP_EN to enable the DUP command; otherwise DUP reports illegal.
module rpn_controller
    import rpn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    rpn_if.slave                       bus,
    output logic [7:0]                 alu_ain_o,
    output logic [7:0]                 alu_bin_o,
    output logic [2:0]                 alu_op_o,
    input  logic [7:0]                 alu_out_i,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int DW = $clog2(DEPTH + 1);

    state_e     state_q, state_d;
    cmd_e       op_q, op_d;
    logic [7:0] data_q, data_d, res_q, res_d;
    logic [7:0] ain_q, ain_d, bin_q, bin_d;
    logic [2:0] aop_q, aop_d;
    logic [1:0] err_q, err_d, chk_err;
    logic       push, pop, pop2push, repl, dup_cmd, need1, need2;
    logic [7:0] wdata, push_data, tos, nos;

    rpn_stack #(.DEPTH(DEPTH)) u_stack (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .pop2push_i (pop2push),
        .repl_i     (repl),
        .wdata_i    (wdata),
        .tos_o      (tos),
        .nos_o      (nos),
        .depth_o    (depth_o),
        .full_o     (full_o),
        .empty_o    (empty_o)
    );

`ifdef RPN_DUP_EN
    assign dup_cmd   = op_q == CMD_DUP;
    assign push_data = dup_cmd ? tos : data_q;
`else
    assign dup_cmd   = 1'b0;
    assign push_data = data_q;
`endif

    // Illegal DUP outranks underflow so a disabled DUP always reports 11
    always_comb begin
        need2   = op_q inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_OR};
        need1   = op_q inside {CMD_NOT, CMD_POP, CMD_DUP};
        chk_err = (op_q == CMD_DUP && !dup_cmd) ? ERR_ILL :
                  ((need2 && depth_o < DW'(2)) || (need1 && empty_o)) ? ERR_UNDER :
                  ((op_q == CMD_PUSH || dup_cmd) && full_o) ? ERR_OVER : ERR_OK;
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        res_d         = res_q;
        err_d         = err_q;
        ain_d         = ain_q;
        bin_d         = bin_q;
        aop_d         = aop_q;
        push          = 1'b0;
        pop           = 1'b0;
        pop2push      = 1'b0;
        repl          = 1'b0;
        wdata         = push_data;
        bus.cmd_ready = state_q == S_IDLE && !reset;
        bus.rsp_valid = state_q == S_RESP;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = S_CHECK;
                    op_d    = cmd_e'(bus.cmd_op);
                    data_d  = bus.cmd_data;
                end
            end
            S_CHECK: begin
                err_d = chk_err;
                if (chk_err != ERR_OK) begin
                    state_d = S_RESP;
                end else if (op_q == CMD_PUSH || op_q == CMD_POP || dup_cmd) begin
                    push    = op_q != CMD_POP;
                    pop     = op_q == CMD_POP;
                    state_d = S_RESP;
                end else begin
                    ain_d   = op_q == CMD_NOT ? tos : nos;
                    bin_d   = op_q == CMD_NOT ? 8'h00 : tos;
                    aop_d   = alu_op_of(op_q);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_out_i;
                state_d = S_WB;
            end
            S_WB: begin
                repl     = op_q == CMD_NOT;
                pop2push = op_q != CMD_NOT;
                wdata    = res_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= CMD_PUSH;
            data_q  <= '0;
            res_q   <= '0;
            err_q   <= ERR_OK;
            ain_q   <= '0;
            bin_q   <= '0;
            aop_q   <= ALU_ADD;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            res_q   <= res_d;
            err_q   <= err_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            aop_q   <= aop_d;
        end
    end

    assign bus.rsp_top = tos;
    assign bus.rsp_err = err_q;
    assign alu_ain_o   = ain_q;
    assign alu_bin_o   = bin_q;
    assign alu_op_o    = aop_q;
endmodule

// File: tb/tb_rpn_controller.sv
// tb_rpn_controller: directed vector bench for rpn_controller with a behavioural ALU.
module tb_rpn_controller;
    import rpn_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] top;
        logic [1:0] err;
        int         dep;
        int         lat;
        bit         alu;
        logic [7:0] ain;
        logic [7:0] bin;
        logic [2:0] aop;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] alu_ain, alu_bin, alu_out;
    logic [2:0] alu_op;
    logic [3:0] depth;
    logic       full, empty;
    int         checks = 0;
    int         errors = 0;
    vec_t       vq[$];

    rpn_if bus ();

    rpn_controller #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .alu_ain_o (alu_ain),
        .alu_bin_o (alu_bin),
        .alu_op_o  (alu_op),
        .alu_out_i (alu_out),
        .depth_o   (depth),
        .full_o    (full),
        .empty_o   (empty)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            ALU_ADD: alu_out = alu_ain + alu_bin;
            ALU_SUB: alu_out = alu_ain - alu_bin;
            ALU_AND: alu_out = alu_ain & alu_bin;
            ALU_NOT: alu_out = ~alu_ain;
            ALU_OR:  alu_out = alu_ain | alu_bin;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t sv(logic [2:0] op, logic [7:0] data, logic [7:0] top, logic [1:0] err, int dep);
        vec_t r;
        r.op = op; r.data = data; r.top = top; r.err = err; r.dep = dep;
        r.lat = 2; r.alu = 1'b0; r.ain = 8'h00; r.bin = 8'h00; r.aop = 3'b000;
        return r;
    endfunction

    function automatic vec_t av(logic [2:0] op, logic [7:0] top, int dep, logic [7:0] ain, logic [7:0] bin, logic [2:0] aop);
        vec_t r;
        r = sv(op, 8'h00, top, ERR_OK, dep);
        r.lat = 4; r.alu = 1'b1; r.ain = ain; r.bin = bin; r.aop = aop;
        return r;
    endfunction

    // Offers one command, returns once rsp_valid is seen (sampled at negedges).
    task automatic issue(input logic [2:0] op, input logic [7:0] data, output logic [7:0] top,
                         output logic [1:0] err, output int lat, output logic [7:0] ain,
                         output logic [7:0] bin, output logic [2:0] aop);
        int n;
        n = 0;
        lat = -1; top = 8'h00; err = 2'b00; ain = 8'h00; bin = 8'h00; aop = 3'b000;
        @(negedge clk);
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready wait: got 0 expected 1 within 20 cycles");
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                ain = alu_ain; bin = alu_bin; aop = alu_op;
            end
        end while (!bus.rsp_valid && n < 20);
        lat = n;
        top = bus.rsp_top;
        err = bus.rsp_err;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        logic [7:0] top, ain, bin;
        logic [1:0] err;
        logic [2:0] aop;
        int lat;
        issue(v.op, v.data, top, err, lat, ain, bin, aop);
        chk({nm, " top"}, top, v.top);
        chk({nm, " err"}, err, v.err);
        chk({nm, " lat"}, lat, v.lat);
        chk({nm, " depth"}, depth, v.dep);
        chk({nm, " full"}, full, int'(v.dep == DEPTH));
        chk({nm, " empty"}, empty, int'(v.dep == 0));
        if (v.alu) begin
            chk({nm, " ain"}, ain, v.ain);
            chk({nm, " bin"}, bin, v.bin);
            chk({nm, " aop"}, aop, v.aop);
        end
        finish_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] top, ain, bin;
        logic [1:0] err;
        logic [2:0] aop;
        int lat;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;

        vq.push_back(sv(CMD_PUSH, 8'd5, 8'd5, ERR_OK, 1));
        vq.push_back(sv(CMD_PUSH, 8'd3, 8'd3, ERR_OK, 2));
        vq.push_back(av(CMD_SUB, 8'd2, 1, 8'd5, 8'd3, ALU_SUB));
        vq.push_back(sv(CMD_POP, 8'd0, 8'd0, ERR_OK, 0));
        vq.push_back(sv(CMD_PUSH, 8'd200, 8'd200, ERR_OK, 1));
        vq.push_back(sv(CMD_PUSH, 8'd100, 8'd100, ERR_OK, 2));
        vq.push_back(av(CMD_ADD, 8'h2C, 1, 8'd200, 8'd100, ALU_ADD));
        vq.push_back(sv(CMD_PUSH, 8'h0F, 8'h0F, ERR_OK, 2));
        vq.push_back(av(CMD_NOT, 8'hF0, 2, 8'h0F, 8'h00, ALU_NOT));
        vq.push_back(sv(CMD_POP, 8'd0, 8'h2C, ERR_OK, 1));
        vq.push_back(sv(CMD_POP, 8'd0, 8'h00, ERR_OK, 0));
        vq.push_back(sv(CMD_ADD, 8'd0, 8'h00, ERR_UNDER, 0));
        vq.push_back(sv(CMD_POP, 8'd0, 8'h00, ERR_UNDER, 0));
        vq.push_back(sv(CMD_PUSH, 8'd9, 8'd9, ERR_OK, 1));
        vq.push_back(sv(CMD_OR, 8'd0, 8'd9, ERR_UNDER, 1));
        vq.push_back(sv(CMD_PUSH, 8'hAA, 8'hAA, ERR_OK, 2));
        vq.push_back(av(CMD_OR, 8'hAB, 1, 8'd9, 8'hAA, ALU_OR));
        vq.push_back(sv(CMD_PUSH, 8'h0F, 8'h0F, ERR_OK, 2));
        vq.push_back(av(CMD_AND, 8'h0B, 1, 8'hAB, 8'h0F, ALU_AND));
        vq.push_back(sv(CMD_PUSH, 8'h0C, 8'h0C, ERR_OK, 2));
        vq.push_back(av(CMD_SUB, 8'hFF, 1, 8'h0B, 8'h0C, ALU_SUB));
        vq.push_back(sv(CMD_POP, 8'd0, 8'h00, ERR_OK, 0));
        for (int i = 1; i <= DEPTH; i++)
            vq.push_back(sv(CMD_PUSH, 8'(i), 8'(i), ERR_OK, i));
        vq.push_back(sv(CMD_PUSH, 8'd9, 8'd8, ERR_OVER, 8));
        vq.push_back(sv(CMD_POP, 8'd0, 8'd7, ERR_OK, 7));
`ifdef RPN_DUP_EN
        vq.push_back(sv(CMD_DUP, 8'd0, 8'd7, ERR_OK, 8));
        vq.push_back(sv(CMD_DUP, 8'd0, 8'd7, ERR_OVER, 8));
`else
        vq.push_back(sv(CMD_DUP, 8'd0, 8'd7, ERR_ILL, 7));
        vq.push_back(sv(CMD_DUP, 8'd0, 8'd7, ERR_ILL, 7));
`endif

        // Reset state, checked while reset is still asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cmd_ready", bus.cmd_ready, 0);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst rsp_top", bus.rsp_top, 0);
        chk("rst rsp_err", bus.rsp_err, 0);
        chk("rst depth", depth, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst alu_ain", alu_ain, 0);
        chk("rst alu_bin", alu_bin, 0);
        chk("rst alu_op", alu_op, 0);
        reset = 1'b0;

        foreach (vq[i]) run_vec($sformatf("v%0d", i), vq[i]);

        // Response back-pressure: everything holds while rsp_ready is low
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        issue(CMD_PUSH, 8'h33, top, err, lat, ain, bin, aop);
        chk("stall lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d rsp_valid", i), bus.rsp_valid, 1);
            chk($sformatf("stall%0d rsp_top", i), bus.rsp_top, 8'h33);
            chk($sformatf("stall%0d rsp_err", i), bus.rsp_err, 0);
            chk($sformatf("stall%0d cmd_ready", i), bus.cmd_ready, 0);
        end
        finish_rsp();
        @(negedge clk);
        chk("post-rsp cmd_ready", bus.cmd_ready, 1);
        chk("post-rsp rsp_valid", bus.rsp_valid, 0);

        // Reset during EXEC aborts the command and clears the stack
        issue(CMD_PUSH, 8'd4, top, err, lat, ain, bin, aop);
        finish_rsp();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = CMD_ADD;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("exec alu_ain", alu_ain, 8'h33);
        chk("exec alu_bin", alu_bin, 8'd4);
        chk("exec alu_op", alu_op, ALU_ADD);
        reset = 1'b1;
        @(negedge clk);
        chk("abort cmd_ready in reset", bus.cmd_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort%0d rsp_valid", i), bus.rsp_valid, 0);
        end
        chk("abort depth", depth, 0);
        chk("abort empty", empty, 1);
        chk("abort cmd_ready", bus.cmd_ready, 1);
        chk("abort alu_ain", alu_ain, 0);

        // PUSH 7, DUP from a fresh stack
        run_vec("dup push", sv(CMD_PUSH, 8'd7, 8'd7, ERR_OK, 1));
`ifdef RPN_DUP_EN
        run_vec("dup", sv(CMD_DUP, 8'd0, 8'd7, ERR_OK, 2));
`else
        run_vec("dup", sv(CMD_DUP, 8'd0, 8'd7, ERR_ILL, 1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
